// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: opcodes, functs, FSM states, ALU controls.
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StExecI   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StHalt    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4
  } alu_ctl_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // States in which an instruction retires (each returns to fetch next).
  function automatic logic is_final(input state_e s);
    return (s == StMemWb) || (s == StMemWr) || (s == StRWb) || (s == StIWb) ||
           (s == StBranch) || (s == StJump);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add, sub, and, or, signed slt, plus zero flag on the result.
module mc_alu
  import mc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctl_e    ctl_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  // Result select by ALU control.
  always_comb begin
    y_o = '0;
    unique case (ctl_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluSlt:  y_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
      default: y_o = a_i + b_i;
    endcase
    zero_o = (y_o == 32'd0);
  end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core with unified word-addressed memory and a program port.
// Optional feature: define MULTICYCLE_CORE_BNE_EN to support bne (opcode 05).
module multicycle_core
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned NREG      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                  prog_wdata,
  input  logic [4:0]                   dbg_raddr,
  output logic [31:0]                  dbg_rdata,
  output logic [31:0]                  pc,
  output logic [3:0]                   state,
  output logic                         instr_done,
  output logic                         halted
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned RW = $clog2(NREG);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic        instr_done_q, instr_done_d;
  logic        halted_q, halted_d;

  logic [31:0] rf_q [NREG];
  logic [31:0] mem_q [MEM_WORDS];

  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          core_mem_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_zero;
  alu_ctl_e    alu_ctl;
  alu_ctl_e    r_ctl;
  logic        funct_ok;

  // Instruction fields; register specifiers are reduced modulo NREG.
  logic [5:0]    opcode, funct;
  logic [4:0]    rs_f, rt_f, rd_f;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx;
  logic [31:0]   simm;

  assign opcode = ir_q[31:26];
  assign rs_f   = ir_q[25:21];
  assign rt_f   = ir_q[20:16];
  assign rd_f   = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign rs_idx = rs_f[RW-1:0];
  assign rt_idx = rt_f[RW-1:0];
  assign rd_idx = rd_f[RW-1:0];
  assign simm   = sext16(ir_q[15:0]);

  mc_alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .ctl_i  (alu_ctl),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // R-type funct decode; unknown functs send the core to HALT.
  always_comb begin
    funct_ok = 1'b1;
    r_ctl    = AluAdd;
    unique case (funct)
      FnAdd:   r_ctl = AluAdd;
      FnSub:   r_ctl = AluSub;
      FnAnd:   r_ctl = AluAnd;
      FnOr:    r_ctl = AluOr;
      FnSlt:   r_ctl = AluSlt;
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state, datapath register updates and shared-ALU operand steering.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    core_mem_we = 1'b0;
    alu_a       = pc_q;
    alu_b       = 32'd4;
    alu_ctl     = AluAdd;

    unique case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = mem_q[pc_q[AW+1:2]];
          pc_d    = alu_y;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d       = rf_q[rs_idx];
        b_d       = rf_q[rt_idx];
        alu_b     = {simm[29:0], 2'b00};
        alu_out_d = alu_y;
        case (opcode)
          OpRtype: state_d = funct_ok ? StExecR : StHalt;
          OpLw,
          OpSw:    state_d = StMemAddr;
          OpAddi:  state_d = StExecI;
          OpBeq:   state_d = StBranch;
`ifdef MULTICYCLE_CORE_BNE_EN
          OpBne:   state_d = StBranch;
`endif
          OpJ:     state_d = StJump;
          default: state_d = StHalt;
        endcase
      end
      StMemAddr: begin
        alu_a     = a_q;
        alu_b     = simm;
        alu_out_d = alu_y;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mdr_d   = mem_q[alu_out_q[AW+1:2]];
        state_d = StMemWb;
      end
      StMemWb: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = mdr_q;
        state_d  = StFetch;
      end
      StMemWr: begin
        core_mem_we = 1'b1;
        state_d     = StFetch;
      end
      StExecR: begin
        alu_a     = a_q;
        alu_b     = b_q;
        alu_ctl   = r_ctl;
        alu_out_d = alu_y;
        state_d   = StRWb;
      end
      StRWb: begin
        rf_we    = 1'b1;
        rf_waddr = rd_idx;
        rf_wdata = alu_out_q;
        state_d  = StFetch;
      end
      StExecI: begin
        alu_a     = a_q;
        alu_b     = simm;
        alu_out_d = alu_y;
        state_d   = StIWb;
      end
      StIWb: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = alu_out_q;
        state_d  = StFetch;
      end
      StBranch: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_ctl = AluSub;
`ifdef MULTICYCLE_CORE_BNE_EN
        if ((opcode == OpBne) ? !alu_zero : alu_zero) pc_d = alu_out_q;
`else
        if (alu_zero) pc_d = alu_out_q;
`endif
        state_d = StFetch;
      end
      StJump: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    instr_done_d = is_final(state_d);
    halted_d     = (state_d == StHalt);
  end

  // FSM, datapath registers and register file; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_out_q    <= '0;
      mdr_q        <= '0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_out_q    <= alu_out_d;
      mdr_q        <= mdr_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
      // r0 is never written, so it always reads as zero.
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Store writes take the memory port; the program port only while stopped.
  assign mem_we    = core_mem_we || (prog_we && !run);
  assign mem_waddr = core_mem_we ? alu_out_q[AW+1:2] : prog_addr;
  assign mem_wdata = core_mem_we ? b_q : prog_wdata;

  // Unified memory; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign dbg_rdata  = rf_q[dbg_raddr[RW-1:0]];
  assign pc         = pc_q;
  assign state      = state_q;
  assign instr_done = instr_done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed program plus random programs against an ISA-level model.
module tb_multicycle_core;

  localparam int MemWords = 64;
  localparam logic [31:0] HaltWord = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] pc;
  logic [3:0]  state;
  logic        instr_done;
  logic        halted;

  always #5 clk = ~clk;

  multicycle_core #(
    .MEM_WORDS (64),
    .RESET_PC  (32'h0),
    .NREG      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .pc         (pc),
    .state      (state),
    .instr_done (instr_done),
    .halted     (halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [MemWords];
  logic [31:0] m_regs [32];
  logic [31:0] prog_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = a[5:0];
    prog_wdata = d;
    @(negedge clk);
    prog_we    = 1'b0;
    m_mem[a]   = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_done) pulses++;
    end
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    dbg_raddr = idx[4:0];
    #1;
    v = dbg_rdata;
  endtask

  // ISA-level reference: run the model memory from address 0 until a halting instruction.
  task automatic model_run(output int cycles, output int ninstr, output logic [31:0] fpc);
    logic [31:0] p, w, s, addr;
    logic [4:0]  rs, rt, rd;
    bit          stop;
    p = 32'h0; cycles = 0; ninstr = 0; stop = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int guard = 0; guard < 500 && !stop; guard++) begin
      w  = m_mem[(p >> 2) % MemWords];
      p  = p + 4;
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      s  = {{16{w[15]}}, w[15:0]};
      addr = m_regs[rs] + s;
      stop = 1;
      case (w[31:26])
        6'h00: begin
          stop = 0;
          case (w[5:0])
            6'h20: m_regs[rd] = m_regs[rs] + m_regs[rt];
            6'h22: m_regs[rd] = m_regs[rs] - m_regs[rt];
            6'h24: m_regs[rd] = m_regs[rs] & m_regs[rt];
            6'h25: m_regs[rd] = m_regs[rs] | m_regs[rt];
            6'h2A: m_regs[rd] = ($signed(m_regs[rs]) < $signed(m_regs[rt])) ? 1 : 0;
            default: stop = 1;
          endcase
          if (!stop) cycles += 4;
        end
        6'h08: begin m_regs[rt] = addr; cycles += 4; stop = 0; end
        6'h23: begin m_regs[rt] = m_mem[(addr >> 2) % MemWords]; cycles += 5; stop = 0; end
        6'h2B: begin m_mem[(addr >> 2) % MemWords] = m_regs[rt]; cycles += 4; stop = 0; end
        6'h04: begin
          if (m_regs[rs] == m_regs[rt]) p = p + (s << 2);
          cycles += 3; stop = 0;
        end
`ifdef MULTICYCLE_CORE_BNE_EN
        6'h05: begin
          if (m_regs[rs] != m_regs[rt]) p = p + (s << 2);
          cycles += 3; stop = 0;
        end
`endif
        6'h02: begin p = {p[31:28], w[25:0], 2'b00}; cycles += 3; stop = 0; end
        default: stop = 1;
      endcase
      m_regs[0] = '0;
      if (stop) cycles += 2;
      else ninstr++;
    end
    fpc = p;
  endtask

  function automatic logic [31:0] rand_instr(input int i, input int n);
    logic [5:0]  fns [5];
    logic [4:0]  rs, rt, rd;
    logic [31:0] w;
    int          k;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    k  = $urandom_range(0, 9);
    case (k)
      0, 1: w = enc_i(6'h08, rs, rt, 16'($urandom));
      2, 3: w = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
      4:    w = enc_i(6'h23, 5'd0, rt, 16'(4 * $urandom_range(40, 63)));
      5:    w = enc_i(6'h2B, 5'd0, rt, 16'(4 * $urandom_range(40, 63)));
      6, 7: begin
        if ($urandom_range(0, 1) == 0) rt = rs;
        w = enc_i((k == 6) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, n - 1 - i)));
      end
      8:    w = enc_j(26'($urandom_range(i + 1, n)));
      default: w = ($urandom_range(0, 3) == 0) ? enc_r(rs, rt, rd, 6'h3F)
                                               : enc_i(6'h08, rs, rt, 16'($urandom));
    endcase
    return w;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          p, cyc, ninstr, exp_cyc, pulses;
    logic [31:0] v, mpc, frozen_pc;
    bit          done;

    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    dbg_raddr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_done", 32'(instr_done), 32'd0);
    read_reg(5, v);
    check_eq("rst_r5", v, 32'h0);

    // Directed program
    for (int i = 0; i < MemWords; i++) write_word(i, HaltWord);
    prog_q = {enc_i(6'h08, 0, 18, 60), enc_i(6'h08, 0, 19, 30), enc_r(18, 19, 20, 6'h20),
              enc_i(6'h08, 0, 17, 99), enc_i(6'h2B, 0, 17, 8), enc_i(6'h23, 0, 9, 8),
              enc_i(6'h08, 0, 10, 4), enc_i(6'h08, 0, 11, 4), enc_i(6'h04, 10, 11, 3),
              HaltWord, HaltWord, HaltWord,
              enc_i(6'h08, 11, 11, 1), enc_i(6'h04, 10, 11, 3), enc_j(26'd15),
              enc_i(6'h08, 0, 0, 5), enc_i(6'h05, 10, 11, 1), HaltWord, HaltWord};
    foreach (prog_q[i]) write_word(i, prog_q[i]);
    do_reset();
    step(3, p);
    check_eq("idle_pc", pc, 32'h0);
    check_eq("idle_state", 32'(state), 32'd0);
    run = 1'b1;
    step(8, p);
    check_eq("addi_pc", pc, 32'd8);
    check_eq("addi_pulses", p, 2);
    step(4, p);
    read_reg(20, v);
    check_eq("add_r20", v, 32'd90);
    check_eq("add_pc", pc, 32'd12);
    check_eq("add_pulses", p, 1);
    step(4, p);
    step(4, p);
    check_eq("sw_pulses", p, 1);
    check_eq("sw_pc", pc, 32'd20);
    step(4, p);
    read_reg(9, v);
    check_eq("lw_pending_r9", v, 32'h0);
    check_eq("lw_state_wb", 32'(state), 32'd4);
    check_eq("lw_pulses", p, 1);
    step(1, p);
    read_reg(9, v);
    check_eq("lw_r9", v, 32'd99);
    check_eq("lw_pc", pc, 32'd24);
    step(8, p);
    step(3, p);
    check_eq("beq_taken_pc", pc, 32'd48);
    step(4, p);
    step(3, p);
    check_eq("beq_nt_pc", pc, 32'd56);
    step(3, p);
    check_eq("j_pc", pc, 32'd60);
    step(4, p);
    read_reg(0, v);
    check_eq("r0_zero", v, 32'h0);
`ifdef MULTICYCLE_CORE_BNE_EN
    step(3, p);
    check_eq("bne_pc", pc, 32'd72);
    check_eq("bne_not_halted", 32'(halted), 32'd0);
    step(2, p);
    frozen_pc = 32'd76;
`else
    step(2, p);
    frozen_pc = 32'd68;
`endif
    check_eq("halt_flag", 32'(halted), 32'd1);
    check_eq("halt_pc", pc, frozen_pc);
    step(20, p);
    check_eq("frozen_pc", pc, frozen_pc);
    check_eq("frozen_state", 32'(state), 32'd12);
    check_eq("frozen_pulses", p, 0);
    read_reg(20, v);
    check_eq("frozen_r20", v, 32'd90);

    // Reset during the write-back state of lw
    run = 1'b0;
    write_word(40, 32'h0000_1234);
    write_word(0, enc_i(6'h23, 0, 9, 160));
    do_reset();
    run = 1'b1;
    step(4, p);
    check_eq("abort_state_wb", 32'(state), 32'd4);
    reset = 1'b1;
    #1;
    read_reg(9, v);
    check_eq("abort_r9", v, 32'h0);
    check_eq("abort_pc", pc, 32'h0);
    check_eq("abort_state", 32'(state), 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random programs against the reference model
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(8, 20);
      for (int i = 0; i < n; i++) write_word(i, rand_instr(i, n));
      write_word(n, HaltWord);
      for (int i = 40; i < MemWords; i++) write_word(i, $urandom);
      model_run(exp_cyc, ninstr, mpc);
      do_reset();
      run = 1'b1;
      cyc = 0; pulses = 0; done = 0;
      while (!done && cyc < 1000) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (instr_done) pulses++;
        if (halted) done = 1;
      end
      check_eq($sformatf("rnd%0d_halted", t), 32'(done), 32'd1);
      check_eq($sformatf("rnd%0d_cycles", t), cyc, exp_cyc);
      check_eq($sformatf("rnd%0d_retired", t), pulses, ninstr);
      check_eq($sformatf("rnd%0d_pc", t), pc, mpc);
      for (int r = 0; r < 32; r++) begin
        read_reg(r, v);
        check_eq($sformatf("rnd%0d_r%0d", t, r), v, m_regs[r]);
      end
      run = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
